// File: rtl/noc_flit_injector_80.sv
// Packet-to-flit transmitter for one 80-bit NoC switch input port.
// A single output register holds each flit and re-presents it while the switch refuses it.
`ifndef FTYPEWD
`define FTYPEWD 2
`endif

module noc_flit_injector_80 #(
  parameter int FLIT_W  = 80,
  parameter int FTYPE_W = `FTYPEWD,
  parameter int ROUTE_W = 24,
  parameter int INFO_W  = FLIT_W - FTYPE_W - ROUTE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hdr_valid,
  output logic                      hdr_ready,
  input  logic                      hdr_single,
  input  logic [ROUTE_W-1:0]        hdr_route,
  input  logic [INFO_W-1:0]         hdr_info,
  input  logic                      dat_valid,
  output logic                      dat_ready,
  input  logic [FLIT_W-FTYPE_W-1:0] dat_word,
  input  logic                      dat_last,
  output logic [FLIT_W-1:0]         FLIT_out,
  output logic                      VALID_out,
  input  logic                      nack_in,
  output logic [15:0]               pkt_count,
  output logic [15:0]               stall_count
);

  localparam logic [FTYPE_W-1:0] ENC_PAYL = FTYPE_W'(0);
  localparam logic [FTYPE_W-1:0] ENC_HEAD = FTYPE_W'(1);
  localparam logic [FTYPE_W-1:0] ENC_TAIL = FTYPE_W'(2);
  localparam logic [FTYPE_W-1:0] ENC_SING = FTYPE_W'(3);

  typedef enum logic {IDLE, BODY} state_t;

  state_t              state_q;
  state_t              state_d;
  logic [FLIT_W-1:0]   flit_p1;
  logic                vld_p1;
  logic [FLIT_W-1:0]   flit_p0;
  logic                vld_p0;
  logic                load_ok;
  logic                hdr_hs;
  logic                dat_hs;
  logic                flit_moves;
  logic                flit_stalls;
  logic [15:0]         pkt_q;
  logic [15:0]         stall_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic ends_packet(input logic [FTYPE_W-1:0] t);
    return (t == ENC_TAIL) || (t == ENC_SING);
  endfunction

  // The output register may take a new flit when it is empty or its flit leaves this cycle.
  assign load_ok     = ~vld_p1 | ~nack_in;
  assign hdr_hs      = hdr_valid & hdr_ready;
  assign dat_hs      = dat_valid & dat_ready;
  assign flit_moves  = vld_p1 & ~nack_in;
  assign flit_stalls = vld_p1 & nack_in;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hdr_hs && !hdr_single) state_d = BODY;
      BODY:    if (dat_hs && dat_last)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hdr_ready = 1'b0;
    dat_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    hdr_ready = load_ok;
        BODY:    dat_ready = load_ok;
        default: ;
      endcase
    end
  end

  // Stage p0: format the flit offered by whichever handshake fires.
  always_comb begin
    flit_p0 = flit_p1;
    vld_p0  = hdr_hs | dat_hs;
    if (hdr_hs)
      flit_p0 = {hdr_info, hdr_route, hdr_single ? ENC_SING : ENC_HEAD};
    else if (dat_hs)
      flit_p0 = {dat_word, dat_last ? ENC_TAIL : ENC_PAYL};
  end

  // Stage p1: output register, frozen bit-for-bit while the switch refuses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      flit_p1 <= '0;
    end else if (load_ok) begin
      vld_p1  <= vld_p0;
      flit_p1 <= flit_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q   <= '0;
      stall_q <= '0;
    end else begin
      if (flit_moves && ends_packet(flit_p1[FTYPE_W-1:0])) pkt_q <= pkt_q + 16'd1;
      if (flit_stalls) stall_q <= sat_inc16(stall_q);
    end
  end

  assign FLIT_out    = flit_p1;
  assign VALID_out   = vld_p1;
  assign pkt_count   = pkt_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_noc_flit_injector_80.sv
// Directed bench for noc_flit_injector_80: inputs change 1 ns after the rising edge,
// outputs are sampled 2 ns after it.
module tb_noc_flit_injector_80;

  localparam logic [1:0] T_PAYL = 2'd0;
  localparam logic [1:0] T_HEAD = 2'd1;
  localparam logic [1:0] T_TAIL = 2'd2;
  localparam logic [1:0] T_SING = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        hdr_valid;
  logic        hdr_ready;
  logic        hdr_single;
  logic [23:0] hdr_route;
  logic [53:0] hdr_info;
  logic        dat_valid;
  logic        dat_ready;
  logic [77:0] dat_word;
  logic        dat_last;
  logic [79:0] FLIT_out;
  logic        VALID_out;
  logic        nack_in;
  logic [15:0] pkt_count;
  logic [15:0] stall_count;

  int checks   = 0;
  int failures = 0;

  noc_flit_injector_80 dut (
    .clk(clk), .rst(rst),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_single(hdr_single),
    .hdr_route(hdr_route), .hdr_info(hdr_info),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_word(dat_word), .dat_last(dat_last),
    .FLIT_out(FLIT_out), .VALID_out(VALID_out), .nack_in(nack_in),
    .pkt_count(pkt_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] hflit(input logic [53:0] info, input logic [23:0] route,
                                        input logic [1:0] t);
    return {info, route, t};
  endfunction

  function automatic logic [79:0] dflit(input logic [77:0] w, input logic [1:0] t);
    return {w, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hdr_valid = 1'b1; hdr_single = 1'b1; hdr_route = 24'h1; hdr_info = '0;
    dat_valid = 1'b0; dat_word = '0; dat_last = 1'b0; nack_in = 1'b0;
    tick(); tick();
    settle();
    checks++; if (hdr_ready !== 1'b0) begin failures++; $display("FAIL rst_hdr_ready got=%b exp=0", hdr_ready); end
    checks++; if (VALID_out !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", VALID_out); end
    checks++; if (FLIT_out !== 80'd0) begin failures++; $display("FAIL rst_flit got=%h exp=0", FLIT_out); end
    checks++; if (pkt_count !== 16'd0 || stall_count !== 16'd0) begin failures++;
      $display("FAIL rst_counters got=%h/%h exp=0/0", pkt_count, stall_count); end
    tick();
    rst = 1'b0; hdr_valid = 1'b0;
  endtask

  task automatic test_single();
    tick();
    hdr_valid = 1'b1; hdr_single = 1'b1; hdr_route = 24'h000005; hdr_info = 54'h123;
    settle();
    checks++; if (hdr_ready !== 1'b1) begin failures++; $display("FAIL single_hdr_ready got=%b exp=1", hdr_ready); end
    tick();
    hdr_valid = 1'b0;
    settle();
    checks++; if (VALID_out !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", VALID_out); end
    checks++; if (FLIT_out !== hflit(54'h123, 24'h5, T_SING)) begin failures++;
      $display("FAIL single_flit got=%h exp=%h", FLIT_out, hflit(54'h123, 24'h5, T_SING)); end
    checks++; if (FLIT_out[4:2] !== 3'd5) begin failures++; $display("FAIL single_hop0 got=%0d exp=5", FLIT_out[4:2]); end
    tick();
    settle();
    checks++; if (VALID_out !== 1'b0) begin failures++; $display("FAIL single_gone got=%b exp=0", VALID_out); end
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL single_pkt got=%0d exp=1", pkt_count); end
  endtask

  task automatic test_four_flit();
    logic [77:0] w [3];
    w[0] = 78'h2AAABBBBCCCCDDDDEEE1; w[1] = 78'h0000000000000000F0F2; w[2] = 78'h3FFFF00000000000ABC3;
    tick();
    hdr_valid = 1'b1; hdr_single = 1'b0; hdr_route = 24'hABCDEF; hdr_info = 54'h2_0000_0000_0001;
    tick();
    hdr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dat_valid = 1'b1; dat_word = w[i]; dat_last = (i == 2);
      settle();
      checks++; if (dat_ready !== 1'b1) begin failures++; $display("FAIL four_dat_ready[%0d] got=%b exp=1", i, dat_ready); end
      if (i == 0) begin
        checks++; if (VALID_out !== 1'b1 || FLIT_out !== hflit(54'h2_0000_0000_0001, 24'hABCDEF, T_HEAD)) begin failures++;
          $display("FAIL four_head got=%b/%h", VALID_out, FLIT_out); end
      end else begin
        checks++; if (VALID_out !== 1'b1 || FLIT_out !== dflit(w[i-1], T_PAYL)) begin failures++;
          $display("FAIL four_payl[%0d] got=%b/%h exp=1/%h", i, VALID_out, FLIT_out, dflit(w[i-1], T_PAYL)); end
      end
      tick();
    end
    dat_valid = 1'b0; dat_last = 1'b0;
    settle();
    checks++; if (VALID_out !== 1'b1 || FLIT_out !== dflit(w[2], T_TAIL)) begin failures++;
      $display("FAIL four_tail got=%b/%h exp=1/%h", VALID_out, FLIT_out, dflit(w[2], T_TAIL)); end
    checks++; if (hdr_ready !== 1'b1 || dat_ready !== 1'b0) begin failures++;
      $display("FAIL four_idle_ready got=%b/%b exp=1/0", hdr_ready, dat_ready); end
    tick();
    settle();
    checks++; if (VALID_out !== 1'b0 || pkt_count !== 16'd2) begin failures++;
      $display("FAIL four_end got=%b/%0d exp=0/2", VALID_out, pkt_count); end
  endtask

  task automatic test_nack_payload();
    logic [77:0] w1, w2;
    w1 = 78'h11112222333344445555; w2 = 78'h0666677778888999900A;
    tick();
    hdr_valid = 1'b1; hdr_single = 1'b0; hdr_route = 24'h000007; hdr_info = 54'h55;
    tick();
    hdr_valid = 1'b0; dat_valid = 1'b1; dat_word = w1; dat_last = 1'b0;
    tick();
    dat_word = w2; dat_last = 1'b1; nack_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (dat_ready !== 1'b0) begin failures++; $display("FAIL nack_dat_ready[%0d] got=%b exp=0", i, dat_ready); end
      checks++; if (VALID_out !== 1'b1 || FLIT_out !== dflit(w1, T_PAYL)) begin failures++;
        $display("FAIL nack_hold[%0d] got=%b/%h exp=1/%h", i, VALID_out, FLIT_out, dflit(w1, T_PAYL)); end
      tick();
    end
    nack_in = 1'b0;
    settle();
    checks++; if (VALID_out !== 1'b1 || FLIT_out !== dflit(w1, T_PAYL) || dat_ready !== 1'b1) begin failures++;
      $display("FAIL nack_release got=%b/%h/%b", VALID_out, FLIT_out, dat_ready); end
    checks++; if (stall_count !== 16'd3) begin failures++; $display("FAIL nack_stall got=%0d exp=3", stall_count); end
    tick();
    dat_valid = 1'b0; dat_last = 1'b0;
    settle();
    checks++; if (VALID_out !== 1'b1 || FLIT_out !== dflit(w2, T_TAIL)) begin failures++;
      $display("FAIL nack_tail got=%b/%h exp=1/%h", VALID_out, FLIT_out, dflit(w2, T_TAIL)); end
    tick();
    settle();
    checks++; if (VALID_out !== 1'b0 || pkt_count !== 16'd3) begin failures++;
      $display("FAIL nack_end got=%b/%0d exp=0/3", VALID_out, pkt_count); end
  endtask

  task automatic test_back_to_back();
    logic [77:0] w;
    w = 78'h1234512345123451234F;
    tick();
    hdr_valid = 1'b1; hdr_single = 1'b0; hdr_route = 24'h000002; hdr_info = 54'h9;
    tick();
    dat_valid = 1'b1; dat_word = w; dat_last = 1'b1;
    hdr_single = 1'b1; hdr_route = 24'h000006; hdr_info = 54'h3C;
    settle();
    checks++; if (hdr_ready !== 1'b0) begin failures++; $display("FAIL b2b_hdr_blocked got=%b exp=0", hdr_ready); end
    tick();
    dat_valid = 1'b0; dat_last = 1'b0;
    settle();
    checks++; if (hdr_ready !== 1'b1) begin failures++; $display("FAIL b2b_hdr_ready got=%b exp=1", hdr_ready); end
    checks++; if (VALID_out !== 1'b1 || FLIT_out !== dflit(w, T_TAIL)) begin failures++;
      $display("FAIL b2b_tail got=%b/%h exp=1/%h", VALID_out, FLIT_out, dflit(w, T_TAIL)); end
    tick();
    hdr_valid = 1'b0;
    settle();
    checks++; if (VALID_out !== 1'b1 || FLIT_out !== hflit(54'h3C, 24'h6, T_SING)) begin failures++;
      $display("FAIL b2b_next got=%b/%h exp=1/%h", VALID_out, FLIT_out, hflit(54'h3C, 24'h6, T_SING)); end
    tick();
    nack_in = 1'b1;
    settle();
    checks++; if (VALID_out !== 1'b0 || hdr_ready !== 1'b1) begin failures++;
      $display("FAIL b2b_idle_nack got=%b/%b exp=0/1", VALID_out, hdr_ready); end
    tick();
    nack_in = 1'b0;
    settle();
    checks++; if (stall_count !== 16'd3 || pkt_count !== 16'd5) begin failures++;
      $display("FAIL b2b_counters got=%0d/%0d exp=3/5", stall_count, pkt_count); end
  endtask

  task automatic test_reset_mid_body();
    tick();
    hdr_valid = 1'b1; hdr_single = 1'b0; hdr_route = 24'h000004; hdr_info = 54'h77;
    tick();
    hdr_valid = 1'b0; dat_valid = 1'b1; dat_word = 78'h5; dat_last = 1'b0; rst = 1'b1;
    settle();
    checks++; if (VALID_out !== 1'b1 || FLIT_out !== hflit(54'h77, 24'h4, T_HEAD)) begin failures++;
      $display("FAIL rmb_head got=%b/%h", VALID_out, FLIT_out); end
    checks++; if (dat_ready !== 1'b0) begin failures++; $display("FAIL rmb_dat_ready_rst got=%b exp=0", dat_ready); end
    tick();
    rst = 1'b0;
    settle();
    checks++; if (VALID_out !== 1'b0 || FLIT_out !== 80'd0) begin failures++;
      $display("FAIL rmb_cleared got=%b/%h exp=0/0", VALID_out, FLIT_out); end
    checks++; if (pkt_count !== 16'd0 || stall_count !== 16'd0) begin failures++;
      $display("FAIL rmb_counters got=%0d/%0d exp=0/0", pkt_count, stall_count); end
    checks++; if (dat_ready !== 1'b0 || hdr_ready !== 1'b1) begin failures++;
      $display("FAIL rmb_idle got=%b/%b exp=0/1", dat_ready, hdr_ready); end
    tick();
    settle();
    checks++; if (VALID_out !== 1'b0) begin failures++; $display("FAIL rmb_dat_ignored got=%b exp=0", VALID_out); end
    dat_valid = 1'b0;
  endtask

  task automatic test_nack_vs_header();
    tick();
    hdr_valid = 1'b1; hdr_single = 1'b1; hdr_route = 24'h000001; hdr_info = 54'hA;
    tick();
    hdr_route = 24'h000003; hdr_info = 54'hB; nack_in = 1'b1;
    settle();
    checks++; if (hdr_ready !== 1'b0) begin failures++; $display("FAIL nvh_hdr_ready got=%b exp=0", hdr_ready); end
    tick();
    nack_in = 1'b0;
    settle();
    checks++; if (FLIT_out !== hflit(54'hA, 24'h1, T_SING) || hdr_ready !== 1'b1) begin failures++;
      $display("FAIL nvh_repeat got=%h/%b exp=%h/1", FLIT_out, hdr_ready, hflit(54'hA, 24'h1, T_SING)); end
    tick();
    hdr_valid = 1'b0;
    settle();
    checks++; if (VALID_out !== 1'b1 || FLIT_out !== hflit(54'hB, 24'h3, T_SING)) begin failures++;
      $display("FAIL nvh_second got=%b/%h", VALID_out, FLIT_out); end
    tick();
    settle();
    checks++; if (pkt_count !== 16'd2 || stall_count !== 16'd1) begin failures++;
      $display("FAIL nvh_counters got=%0d/%0d exp=2/1", pkt_count, stall_count); end
  endtask

  task automatic test_stall_saturation();
    tick();
    hdr_valid = 1'b1; hdr_single = 1'b1; hdr_route = 24'h000002; hdr_info = 54'h1;
    tick();
    hdr_valid = 1'b0; nack_in = 1'b1;
    repeat (70000) tick();
    settle();
    checks++; if (stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_value got=%h exp=ffff", stall_count); end
    checks++; if (VALID_out !== 1'b1 || FLIT_out !== hflit(54'h1, 24'h2, T_SING)) begin failures++;
      $display("FAIL sat_hold got=%b/%h", VALID_out, FLIT_out); end
    tick();
    nack_in = 1'b0;
    settle();
    checks++; if (stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_nowrap got=%h exp=ffff", stall_count); end
    tick();
    settle();
    checks++; if (VALID_out !== 1'b0 || pkt_count !== 16'd3) begin failures++;
      $display("FAIL sat_end got=%b/%0d exp=0/3", VALID_out, pkt_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_four_flit();
    test_nack_payload();
    test_back_to_back();
    test_reset_mid_body();
    test_nack_vs_header();
    test_stall_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_flit_injector_80.md
# noc_flit_injector_80

Packet-to-flit transmitter that drives one 80-bit switch input port of the NoC. It takes a packet header (source route plus info bits) and an optional stream of body words from the network-interface core. It emits head/payload/tail/single flits with the type field in the low bits and the route in the path field. Any flit the downstream switch allocator refuses (not_accept on BWDAUX1) is held and re-presented until it is taken. It also keeps per-port packet and stall counters for debug.

## Interface
- FLIT_W, 80, flit width
- FTYPE_W, `FTYPEWD (2), flit type field width, bits [FTYPE_W-1:0]
- ROUTE_W, 24, source route: 8 hops × 3-bit output-port IDs, hop 0 in the low 3 bits
- INFO_W, FLIT_W-FTYPE_W-ROUTE_W (54), head-flit info bits
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high (reset rst, synchronous, active-high; clock clk)
- hdr_valid  input  1  header offered
- hdr_ready  output  1  header taken when hdr_valid & hdr_ready
- hdr_single  input  1  packet is head-only, encoded as ENC_SING
- hdr_route  input  ROUTE_W  source route
- hdr_info  input  INFO_W  head payload bits
- dat_valid  input  1  body word offered
- dat_ready  output  1  body word taken when dat_valid & dat_ready
- dat_word  input  FLIT_W-FTYPE_W  body bits
- dat_last  input  1  last body word, encoded as ENC_TAIL
- FLIT_out  output  FLIT_W  flit to switch input
- VALID_out  output  1  FLIT_out carries a real flit
- nack_in  input  1  switch BWDAUX1: flit presented this cycle not accepted
- pkt_count  output  16  packets fully accepted downstream (tail or single), wraps
- stall_count  output  16  cycles with VALID_out & nack_in, saturates at 0xFFFF

## Operation
- Flit formats:
  - head/single: {hdr_info, hdr_route, type}
  - payload/tail: {dat_word, type}
  - type values come from ENC_HEAD/ENC_PAYL/ENC_TAIL/ENC_SING.
- Output register: FLIT_out and VALID_out are registered. The flit "moves" when VALID_out & ~nack_in. The register may load when load_ok = ~VALID_out | ~nack_in.
- FSM states:
  - IDLE: hdr_ready = load_ok, dat_ready = 0. On a header handshake, load the head flit. If hdr_single, load a single flit and stay in IDLE; otherwise load a head flit and go to BODY.
  - BODY: hdr_ready = 0, dat_ready = load_ok. On a data handshake, load a payload flit, or a tail flit if dat_last. After a tail, return to IDLE.
- When load_ok is high and no handshake occurs, VALID_out goes to 0 next cycle. The block never emits a dummy flit with VALID_out high.
- While VALID_out & nack_in: FLIT_out and VALID_out hold bit-identical values and no upstream handshake occurs. This covers head, payload and tail; the switch's packet lock depends on it.
- The FSM state advances at the upstream handshake, not at the downstream accept. It moves at most one flit ahead.
- pkt_count increments when a tail or single flit moves.
- stall_count increments every cycle with VALID_out & nack_in and saturates at 0xFFFF.
- nack_in is ignored when VALID_out is 0.
- dat_valid in IDLE and hdr_valid in BODY are ignored (ready held low).

## Timing
- Latency: upstream handshake in cycle t → flit on FLIT_out with VALID_out = 1 in cycle t+1.
- Throughput: 1 flit/cycle with nack_in low. Back-to-back packets need no idle gap: a tail in cycle t and the next header in cycle t+1 are legal.
- hdr_ready and dat_ready depend combinationally on nack_in (single-register skid-free stage).
- Reset: on a clock edge with rst = 1, the block clears VALID_out, FLIT_out, pkt_count and stall_count to 0, and sets the FSM to IDLE. hdr_ready and dat_ready are forced to 0 while rst = 1.
- Reset mid-packet abandons the packet with no tail. Upstream must also reset.
- A nack in the same cycle as new upstream data: nack wins, the data is not taken, and the held flit repeats.

## Test plan
- Single packet: hdr_single = 1, route 0x000005, nack_in = 0 → one flit, type ENC_SING, FLIT_out[4:2] = 5, VALID_out for 1 cycle, pkt_count = 1.
- 4-flit packet: header plus 3 words, last with dat_last → flits head, payload, payload, tail on 4 consecutive cycles starting 1 cycle after the header handshake; dat_ready stays high throughout.
- Nack on payload: nack_in = 1 for 3 cycles while the first payload is shown → the same payload is shown for 4 cycles, dat_ready = 0 for 3 cycles, stall_count = 3, flit order is unchanged.
- Back-to-back: tail accepted in cycle t, new header offered in t → hdr_ready high in t+1, head flit in t+2, and no dummy VALID cycle between the packets.
- Reset mid-BODY: assert rst after the head flit → VALID_out = 0 and counters = 0 after the edge; FSM is IDLE (dat_valid is ignored, hdr_ready is high after rst deasserts).
- Stall saturation: hold nack_in = 1 with VALID_out high for 70000 cycles → stall_count = 0xFFFF and does not wrap.
